// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the core's master port and the SRAM responder.
interface axi_sram_slave_if;
  logic        awready;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arready;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  modport slave (
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport master (
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a word-addressed SRAM; independent read and
// write engines, one outstanding transaction each.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting beats until counter == len
// W_RESP | bvalid high, holding the response until bready
// R_IDLE | arready high, waiting for a read address
// R_WAIT | latency down-counter running; beat 0 loads on the exit edge
// R_DATA | rvalid high, one beat per rready handshake
module axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 2
) (
  input logic             clock,
  input logic             reset,
  axi_sram_slave_if.slave io_slave
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rstate_t;

  function automatic logic f_in_range(input logic [31:0] a);
    return (a >= ADDR_BASE) && ((a - ADDR_BASE) < SPAN);
  endfunction

  function automatic logic [AW-1:0] f_idx(input logic [31:0] a);
    return AW'((a - ADDR_BASE) >> 2);
  endfunction

  // FIXED keeps the address; every other burst encoding steps by the beat size
  function automatic logic [31:0] f_step(input logic [31:0] a, input logic [2:0] size,
                                         input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  logic [31:0] r_mem [DEPTH_WORDS];

  // ---------------- write engine ----------------
  wstate_t     r_wstate, w_wstate_nxt;
  logic        r_awready;
  logic [31:0] r_waddr;
  logic [3:0]  r_wid;
  logic [7:0]  r_wlen, r_wcnt;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic        r_werr;
  logic        w_aw_hs, w_wbeat, w_wlast_beat, w_wbeat_ok;
  logic [AW-1:0] w_widx;

  assign w_aw_hs      = io_slave.awvalid && r_awready;
  assign w_wbeat      = io_slave.wvalid && (r_wstate == W_DATA);
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_wbeat_ok   = f_in_range(r_waddr);
  assign w_widx       = f_idx(r_waddr);

  // Write state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  // Write next-state; the burst ends on the beat counter, never on wlast
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_wbeat && w_wlast_beat) w_wstate_nxt = W_RESP;
      W_RESP:  if (io_slave.bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write outputs
  always_comb begin
    io_slave.awready = r_awready;
    io_slave.wready  = (r_wstate == W_DATA);
    io_slave.bvalid  = (r_wstate == W_RESP);
    io_slave.bresp   = ((r_wstate == W_RESP) && r_werr) ? 2'b10 : 2'b00;
    io_slave.bid     = r_wid;
  end

  // Write request latch, beat counter, sticky error and registered awready
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_awready <= 1'b0;
      r_waddr   <= '0;
      r_wid     <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_werr    <= 1'b0;
    end else begin
      r_awready <= (w_wstate_nxt == W_IDLE);
      if (w_aw_hs) begin
        r_waddr  <= io_slave.awaddr;
        r_wid    <= io_slave.awid;
        r_wlen   <= io_slave.awlen;
        r_wsize  <= io_slave.awsize;
        r_wburst <= io_slave.awburst;
        r_wcnt   <= '0;
        r_werr   <= 1'b0;
      end else if (w_wbeat) begin
        r_wcnt  <= r_wcnt + 8'd1;
        r_waddr <= f_step(r_waddr, r_wsize, r_wburst);
        if (!w_wbeat_ok || (io_slave.wlast != w_wlast_beat)) r_werr <= 1'b1;
      end
    end
  end

  // SRAM byte-lane writes; contents deliberately have no reset
  always_ff @(posedge clock) begin
    if (w_wbeat && w_wbeat_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave.wstrb[b]) r_mem[w_widx][8*b +: 8] <= io_slave.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rstate_t     r_rstate, w_rstate_nxt;
  logic        r_arready;
  logic [31:0] r_raddr;
  logic [3:0]  r_rid;
  logic [7:0]  r_rlen, r_rcnt;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [15:0] r_rlat;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast;
  logic        w_ar_hs, w_rbeat, w_rlast_beat, w_rfirst, w_rload;
  logic [31:0] w_raddr_nxt, w_rload_addr;
  logic [7:0]  w_rload_cnt;

  assign w_ar_hs      = io_slave.arvalid && r_arready;
  assign w_rbeat      = io_slave.rready && (r_rstate == R_DATA);
  assign w_rlast_beat = (r_rcnt == r_rlen);
  assign w_rfirst     = (r_rstate == R_WAIT) && (r_rlat == '0);
  assign w_rload      = w_rfirst || (w_rbeat && !w_rlast_beat);
  assign w_raddr_nxt  = f_step(r_raddr, r_rsize, r_rburst);
  assign w_rload_addr = w_rfirst ? r_raddr : w_raddr_nxt;
  assign w_rload_cnt  = w_rfirst ? 8'd0 : r_rcnt + 8'd1;

  // Read state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  // Read next-state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_WAIT;
      R_WAIT:  if (r_rlat == '0) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_rbeat && w_rlast_beat) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read outputs come straight from the beat registers so they hold during stalls
  always_comb begin
    io_slave.arready = r_arready;
    io_slave.rvalid  = (r_rstate == R_DATA);
    io_slave.rdata   = r_rdata;
    io_slave.rresp   = r_rresp;
    io_slave.rlast   = r_rlast;
    io_slave.rid     = r_rid;
  end

  // Read request latch, latency timer and beat register (old data on collision)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_arready <= 1'b0;
      r_raddr   <= '0;
      r_rid     <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rlat    <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rlast   <= 1'b0;
    end else begin
      r_arready <= (w_rstate_nxt == R_IDLE);
      if (w_ar_hs) begin
        r_raddr  <= io_slave.araddr;
        r_rid    <= io_slave.arid;
        r_rlen   <= io_slave.arlen;
        r_rsize  <= io_slave.arsize;
        r_rburst <= io_slave.arburst;
        r_rcnt   <= '0;
        r_rlat   <= 16'(RD_LAT - 1);
      end else if (w_rload) begin
        r_raddr <= w_rload_addr;
        r_rcnt  <= w_rload_cnt;
        r_rlast <= (w_rload_cnt == r_rlen);
        if (f_in_range(w_rload_addr)) begin
          r_rdata <= r_mem[f_idx(w_rload_addr)];
          r_rresp <= 2'b00;
        end else begin
          r_rdata <= '0;
          r_rresp <= 2'b10;
        end
      end else if ((r_rstate == R_WAIT) && (r_rlat != '0)) begin
        r_rlat <= r_rlat - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench: tasks drive AXI transactions and push expected responses
// computed from a byte-level memory model; a negedge monitor checks them.
module tb_axi_sram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          RDL   = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  axi_sram_slave_if io_slave();

  axi_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(RDL)) u_dut (
    .clock    (clock),
    .reset    (reset),
    .io_slave (io_slave)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [7:0] mdl   [4*DEPTH];
  bit         known [4*DEPTH];

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;
  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];

  logic [31:0] wd_a [256];
  logic [3:0]  ws_a [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return a;
    return 32'(longint'(a) + longint'(i) * (longint'(1) << size));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return io_slave.awready;
      1:       return io_slave.wready;
      2:       return io_slave.arready;
      3:       return io_slave.bvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Waits (bounded) for the named ready/valid, then steps past the handshake edge
  task automatic wait_hs(input int which, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (sig(which)) begin
        ok = 1'b1;
        @(posedge clock);
        #1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s: actual=no handshake required=handshake within 100 cycles", name);
    end
  endtask

  // Monitor: pops the scoreboard on every B and R handshake; checks R stall stability
  logic        prev_stall = 1'b0;
  logic [38:0] prev_r = '0;
  bexp_t       mb;
  rexp_t       mr;
  always @(negedge clock) begin
    if (io_slave.bvalid && io_slave.bready) begin
      if (bq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected: actual=bvalid required=no response pending");
      end else begin
        mb = bq.pop_front();
        chk("bresp", io_slave.bresp, mb.resp);
        chk("bid", io_slave.bid, mb.id);
      end
    end
    if (io_slave.rvalid && io_slave.rready) begin
      if (rq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL r_unexpected: actual=rvalid required=no beat pending");
      end else begin
        mr = rq.pop_front();
        chk("rdata", io_slave.rdata & mr.mask, mr.data & mr.mask);
        chk("rresp_rlast_rid", {io_slave.rresp, io_slave.rlast, io_slave.rid},
            {mr.resp, mr.last, mr.id});
      end
    end
    if (prev_stall && io_slave.rvalid)
      chk("r_stable", {io_slave.rdata, io_slave.rresp, io_slave.rlast, io_slave.rid}, prev_r);
    prev_stall = io_slave.rvalid && !io_slave.rready;
    prev_r     = {io_slave.rdata, io_slave.rresp, io_slave.rlast, io_slave.rid};
  end

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int wlast_at, input int bdelay);
    bit          err;
    bit          wl;
    logic [31:0] a;
    int          w;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a  = beat_addr(addr, i, size, burst);
      wl = (wlast_at == int'(len)) ? (i == int'(len)) : (i == wlast_at);
      if (wl != (i == int'(len))) err = 1'b1;
      if (!in_rng(a)) err = 1'b1;
      else begin
        w = widx(a);
        for (int b = 0; b < 4; b++) begin
          if (ws_a[i][b]) begin
            mdl[4*w+b]   = wd_a[i][8*b +: 8];
            known[4*w+b] = 1'b1;
          end
        end
      end
    end
    bq.push_back('{resp: (err ? 2'b10 : 2'b00), id: id});

    io_slave.awaddr  = addr;
    io_slave.awid    = id;
    io_slave.awlen   = len;
    io_slave.awsize  = size;
    io_slave.awburst = burst;
    io_slave.awvalid = 1'b1;
    wait_hs(0, "aw");
    io_slave.awvalid = 1'b0;
    chk("wready_after_aw", io_slave.wready, 1'b1);

    for (int i = 0; i <= int'(len); i++) begin
      io_slave.wvalid = 1'b1;
      io_slave.wdata  = wd_a[i];
      io_slave.wstrb  = ws_a[i];
      io_slave.wlast  = (wlast_at == int'(len)) ? (i == int'(len)) : (i == wlast_at);
      wait_hs(1, "w");
    end
    io_slave.wvalid = 1'b0;
    io_slave.wlast  = 1'b0;
    chk("bvalid_rise", io_slave.bvalid, 1'b1);

    for (int d = 0; d < bdelay; d++) begin
      @(negedge clock);
      chk("bvalid_hold", io_slave.bvalid, 1'b1);
      @(posedge clock);
      #1;
    end
    io_slave.bready = 1'b1;
    wait_hs(3, "b");
    io_slave.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit toggle, input int abort_after);
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] m;
    int          w;
    int          lat;
    int          got;
    int          n;
    bit          seen;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, i, size, burst);
      if (!in_rng(a)) begin
        rq.push_back('{data: 32'h0, mask: 32'hFFFF_FFFF, resp: 2'b10, last: (i == int'(len)), id: id});
      end else begin
        w = widx(a);
        for (int b = 0; b < 4; b++) begin
          d[8*b +: 8] = mdl[4*w+b];
          m[8*b +: 8] = known[4*w+b] ? 8'hFF : 8'h00;
        end
        rq.push_back('{data: d, mask: m, resp: 2'b00, last: (i == int'(len)), id: id});
      end
    end

    io_slave.araddr  = addr;
    io_slave.arid    = id;
    io_slave.arlen   = len;
    io_slave.arsize  = size;
    io_slave.arburst = burst;
    io_slave.arvalid = 1'b1;
    wait_hs(2, "ar");
    io_slave.arvalid = 1'b0;
    io_slave.rready  = toggle ? 1'($urandom % 2) : 1'b1;

    lat  = 0;
    seen = 1'b0;
    while (lat < 20) begin
      @(negedge clock);
      if (io_slave.rvalid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    chk("rd_latency", 64'(lat), 64'(RDL));

    got = 0;
    n   = 0;
    if (seen) begin
      forever begin
        if (io_slave.rvalid && io_slave.rready) got++;
        @(posedge clock);
        #1;
        if (got == int'(len) + 1 || got == abort_after || n > 200) break;
        io_slave.rready = toggle ? 1'($urandom % 2) : 1'b1;
        n++;
        @(negedge clock);
      end
    end
    io_slave.rready = 1'b0;
    if (abort_after < 0) chk("r_beats", 64'(got), 64'(int'(len) + 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  r_id;
  int          r_wl;
  int          sel;

  initial begin
    io_slave.awvalid = 1'b0; io_slave.awaddr = '0; io_slave.awid = '0; io_slave.awlen = '0;
    io_slave.awsize  = '0;   io_slave.awburst = '0;
    io_slave.wvalid  = 1'b0; io_slave.wdata = '0; io_slave.wstrb = '0; io_slave.wlast = 1'b0;
    io_slave.bready  = 1'b0;
    io_slave.arvalid = 1'b0; io_slave.araddr = '0; io_slave.arid = '0; io_slave.arlen = '0;
    io_slave.arsize  = '0;   io_slave.arburst = '0;
    io_slave.rready  = 1'b0;

    #22;
    chk("reset_outputs",
        {io_slave.awready, io_slave.wready, io_slave.bvalid, io_slave.bresp, io_slave.bid,
         io_slave.arready, io_slave.rvalid, io_slave.rresp, io_slave.rdata, io_slave.rlast,
         io_slave.rid}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("readies_before_edge", {io_slave.awready, io_slave.arready}, 2'b00);
    @(posedge clock);
    #1;
    chk("readies_after_edge", {io_slave.awready, io_slave.arready}, 2'b11);

    // single write then read back
    wd_a[0] = 32'hDEAD_BEEF; ws_a[0] = 4'hF;
    do_write(32'h8000_0010, 4'd3, 8'd0, 3'd2, 2'b01, 0, 0);
    do_read(32'h8000_0010, 4'd3, 8'd0, 3'd2, 2'b01, 1'b0, -1);

    // partial-strobe merge
    wd_a[0] = 32'h1122_3344; ws_a[0] = 4'hF;
    do_write(32'h8000_0020, 4'd1, 8'd0, 3'd2, 2'b01, 0, 1);
    wd_a[0] = 32'h0000_AA00; ws_a[0] = 4'h2;
    do_write(32'h8000_0020, 4'd2, 8'd0, 3'd2, 2'b01, 0, 0);
    do_read(32'h8000_0020, 4'd4, 8'd0, 3'd2, 2'b01, 1'b1, -1);

    // INCR burst with a stalled response, read back with rready toggling
    for (int i = 0; i < 4; i++) begin
      wd_a[i] = 32'(i + 1);
      ws_a[i] = 4'hF;
    end
    do_write(32'h8000_0100, 4'd5, 8'd3, 3'd2, 2'b01, 3, 5);
    do_read(32'h8000_0100, 4'd6, 8'd3, 3'd2, 2'b01, 1'b1, -1);

    // out-of-range write must not alias onto word 0; read off the top edge
    wd_a[0] = 32'hCAFE_F00D; ws_a[0] = 4'hF;
    do_write(32'h8000_0000, 4'd7, 8'd0, 3'd2, 2'b01, 0, 0);
    wd_a[0] = 32'h1234_5678; ws_a[0] = 4'hF;
    do_write(32'h0000_0000, 4'd8, 8'd0, 3'd2, 2'b01, 0, 0);
    do_read(32'h8000_0000, 4'd8, 8'd0, 3'd2, 2'b01, 1'b0, -1);
    wd_a[0] = 32'h5A5A_A5A5; ws_a[0] = 4'hF;
    do_write(32'h8000_0FFC, 4'd9, 8'd0, 3'd2, 2'b01, 0, 0);
    do_read(32'h8000_0FFC, 4'd9, 8'd1, 3'd2, 2'b01, 1'b0, -1);

    // early wlast: all four beats still accepted, response is SLVERR
    for (int i = 0; i < 4; i++) begin
      wd_a[i] = 32'hA000_0000 + 32'(i);
      ws_a[i] = 4'hF;
    end
    do_write(32'h8000_0200, 4'd10, 8'd3, 3'd2, 2'b01, 1, 0);
    do_read(32'h8000_0200, 4'd10, 8'd3, 3'd2, 2'b01, 1'b0, -1);

    // reset in the middle of a long read
    for (int i = 0; i < 8; i++) begin
      wd_a[i] = 32'hB000_0000 + 32'(i);
      ws_a[i] = 4'hF;
    end
    do_write(32'h8000_0300, 4'd11, 8'd7, 3'd2, 2'b01, 7, 0);
    do_read(32'h8000_0300, 4'd12, 8'd7, 3'd2, 2'b01, 1'b0, 2);
    reset = 1'b0;
    #1;
    chk("reset_mid_read", {io_slave.rvalid, io_slave.arready, io_slave.awready}, 3'b000);
    rq.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("arready_before_edge", io_slave.arready, 1'b0);
    @(posedge clock);
    #1;
    chk("arready_after_edge", io_slave.arready, 1'b1);
    do_read(32'h8000_0304, 4'd13, 8'd0, 3'd2, 2'b01, 1'b0, -1);

    // randomized bursts checked against the model
    for (int it = 0; it < 40; it++) begin
      r_len   = 8'($urandom % 8);
      r_size  = 3'($urandom % 3);
      r_burst = 2'($urandom % 3);
      r_id    = 4'($urandom % 16);
      sel     = int'($urandom % 10);
      if (sel == 0)      r_addr = BASE + 32'(4 * DEPTH) - 32'(4 * ($urandom % 4));
      else if (sel == 1) r_addr = BASE - 32'd8;
      else               r_addr = BASE + 32'($urandom % (4 * DEPTH - 64));
      r_wl = (($urandom % 8) == 0) ? int'($urandom % (int'(r_len) + 1)) : int'(r_len);
      for (int i = 0; i <= int'(r_len); i++) begin
        wd_a[i] = $urandom;
        ws_a[i] = 4'($urandom % 15 + 1);
      end
      do_write(r_addr, r_id, r_len, r_size, r_burst, r_wl, int'($urandom % 3));
      do_read(r_addr, r_id, r_len, r_size, r_burst, 1'($urandom % 2), -1);
    end

    repeat (5) @(posedge clock);
    #1;
    chk("b_queue_drained", 64'(bq.size()), 64'h0);
    chk("r_queue_drained", 64'(rq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 responder with an internal word-addressed SRAM. It answers the core's AXI4 master port (`io_master_*`) in simulation and in FPGA bring-up, and replaces the external memory model. It supports single-beat and INCR/FIXED bursts with independent read and write channels. Read latency is parameterised so the master's wait states can be exercised.

## Interface
- `ADDR_BASE`, 32'h8000_0000, byte address of word 0.
- `DEPTH_WORDS`, 1024, number of 32-bit words; must be a power of 2.
- `RD_LAT`, 2, cycles from the AR handshake edge to the first `rvalid`; must be ≥1.

- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `io_slave_awready` out 1; `io_slave_awvalid` in 1; `io_slave_awaddr` in 32; `io_slave_awid` in 4; `io_slave_awlen` in 8; `io_slave_awsize` in 3; `io_slave_awburst` in 2.
- `io_slave_wready` out 1; `io_slave_wvalid` in 1; `io_slave_wdata` in 32; `io_slave_wstrb` in 4; `io_slave_wlast` in 1.
- `io_slave_bready` in 1; `io_slave_bvalid` out 1; `io_slave_bresp` out 2; `io_slave_bid` out 4.
- `io_slave_arready` out 1; `io_slave_arvalid` in 1; `io_slave_araddr` in 32; `io_slave_arid` in 4; `io_slave_arlen` in 8; `io_slave_arsize` in 3; `io_slave_arburst` in 2.
- `io_slave_rready` in 1; `io_slave_rvalid` out 1; `io_slave_rresp` out 2; `io_slave_rdata` out 32; `io_slave_rlast` out 1; `io_slave_rid` out 4.

## Operation
- **Independent FSMs.** The write and read FSMs run independently, with one outstanding transaction per direction.
- **Address range.** Word index = (addr − `ADDR_BASE`) >> 2.
  - A beat is out of range if addr < `ADDR_BASE` or addr ≥ `ADDR_BASE` + 4·`DEPTH_WORDS`.
- **Address step.** Burst 2'b00 (FIXED) keeps the address. Every other encoding is treated as INCR: addr += 1 << size on each beat.
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: `awready`=1. On the AW handshake, latch addr, id, len, size and burst, clear the beat counter and the error flag, and go to W_DATA.
  - W_DATA: `wready`=1. Each accepted beat writes the byte lanes whose `wstrb` bit is set. No lane shifting is done; the master places the bytes.
  - Out-of-range beat: no write, and the sticky error flag is set.
  - `wlast` mismatch (`wlast` set on a beat ≠ len, or clear on beat len): the sticky error flag is set.
  - The burst always ends on counter == len; `wlast` does not end it.
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=2'b10 if the error flag is set, else 2'b00. Hold until `bready`, then go to W_IDLE.
- **Read FSM: R_IDLE → R_WAIT → R_DATA → R_IDLE.**
  - R_IDLE: `arready`=1. On the AR handshake, latch the request and go to R_WAIT.
  - R_WAIT: the latency counter runs. `rdata`, `rresp` and `rlast` for beat 0 are registered on the edge entering R_DATA.
  - R_DATA: `rvalid`=1, `rid`=latched id, `rlast`=1 only on beat len.
    - Out-of-range beat: `rdata`=0, `rresp`=2'b10. Otherwise `rresp`=2'b00.
    - On `rvalid`&`rready`: advance address and counter and register the next beat. After the last beat, go to R_IDLE.
- **Collision.** A write and a read to the same word on the same edge: the read returns the old data.
- **Memory.** Contents are not reset.

## Timing
- **Reset values while `reset`=0:** all outputs are 0, including `awready` and `arready`. Both FSMs are idle.
- **Ready flops.** `awready` and `arready` are registered. Each rises on the first `clock` edge after `reset` release. Each drops on the edge that completes its address handshake.
- **Reset mid-transaction.** Asserting `reset` mid-transaction drops `bvalid`, `rvalid` and the readies immediately (asynchronous) and abandons the burst. Writes already committed stay in memory.
- **Read latency.** AR handshake on edge N → `rvalid` high after edge N+`RD_LAT`.
  - Back-to-back beats are 1 per cycle while `rready`=1.
  - `rdata`, `rresp`, `rlast` and `rid` are stable while `rvalid`=1 and `rready`=0.
- **Write throughput.** AW handshake on edge N → `wready` high after edge N. Beats are 1 per cycle.
  - `bvalid` rises after the edge accepting the last beat and is held until `bready`.
- **Next address.** Earliest next AW or AR acceptance is the cycle after the previous response completes.

## Test plan
1. Write 0x8000_0010, data 0xDEADBEEF, strb 0xF, id 3 → `bvalid`, `bid`=3, `bresp`=00. Read the same address, len 0, id 3 → `rdata`=0xDEADBEEF, `rlast`=1, `rid`=3, with `rvalid` exactly 2 cycles after the AR edge.
2. Write 0x11223344, then write strb 0x2 with data 0x0000AA00 to the same word → read returns 0x1122AA44.
3. INCR burst at 0x8000_0100, len 3, size 2, data 1,2,3,4, with `bready` held low 5 cycles → `bvalid` held throughout. Read back the same burst with `rready` toggling → beats 1,2,3,4, `rlast` only on beat 4, outputs stable across stalls.
4. Write 0x0000_0000 → `bresp`=10, memory unchanged. Read 0x8000_0FFC, len 1 → beat 0 `rresp`=00; beat 1 `rresp`=10 with `rdata`=0.
5. Burst of len 3 with `wlast` asserted on beat 1 → `wready` held until 4 beats are accepted, then `bresp`=10.
6. Assert `reset` during beat 2 of a len-7 read → `rvalid`=0 at once. `arready` goes 0, then 1 on the first edge after release. A new single read then completes correctly.
